// File: rtl/mux_serializer_ctrl_pkg.sv
// Shared types and constants for the mux serializer front-end.
// Parity feature enabled by defining MUX_SER_PARITY_EN.
package mux_ser_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_START_UP = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_TERM_UP  = SEL_W'(15);
    localparam logic [SEL_W-1:0] SEL_START_DN = SEL_W'(15);
    localparam logic [SEL_W-1:0] SEL_TERM_DN  = SEL_W'(0);

    // dir = 0 scans upward, dir = 1 scans downward
    function automatic logic [SEL_W-1:0] sel_start(input logic dir);
        return dir ? SEL_START_DN : SEL_START_UP;
    endfunction

    function automatic logic [SEL_W-1:0] sel_term(input logic dir);
        return dir ? SEL_TERM_DN : SEL_TERM_UP;
    endfunction

endpackage

// File: rtl/mux_serializer_ctrl_if.sv
// Bus between the serializer controller and its surroundings (mux and requester).
interface mux_serializer_ctrl_if;
    import mux_ser_pkg::*;

    logic              load;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] w;
    logic [SEL_W-1:0]  s;
    logic              f;
    logic              sout;
    logic              sout_valid;
    logic              busy;
    logic              done;

    modport master (
        output load, data_in, f,
        input  w, s, sout, sout_valid, busy, done
    );

    modport slave (
        input  load, data_in, f,
        output w, s, sout, sout_valid, busy, done
    );

endinterface

// File: rtl/mux_serializer_ctrl_sel_counter.sv
// Loadable up/down select counter; reset and load both go to LD_VAL.
module sel_counter
    import mux_ser_pkg::*;
#(
    parameter logic [SEL_W-1:0] LD_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic             up,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LD_VAL;
        end else if (ld) begin
            cnt <= LD_VAL;
        end else if (en) begin
            cnt <= up ? cnt + SEL_W'(1) : cnt - SEL_W'(1);
        end
    end

    // terminal flag decodes the registered count
    assign tc = (cnt == sel_term(!up));

endmodule

// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial controller driving a 16:1 mux and registering its output.
// Optional trailing even-parity beat when MUX_SER_PARITY_EN is defined.
module mux_serializer_ctrl
    import mux_ser_pkg::*;
#(
    parameter bit DIR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    mux_serializer_ctrl_if.slave bus
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(DIR);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] w_q, w_d;
    logic              sout_q, sout_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cnt_ld_c, cnt_en_c;
    logic              sel_tc;
    logic [SEL_W-1:0]  sel;

`ifdef MUX_SER_PARITY_EN
    logic parity_q, parity_d;
    logic par_beat_q, par_beat_d;
`endif

    sel_counter #(
        .LD_VAL (SEL_START)
    ) u_sel_counter (
        .clk (clk),
        .rst (rst),
        .ld  (cnt_ld_c),
        .en  (cnt_en_c),
        .up  (DIR == 1'b0),
        .cnt (sel),
        .tc  (sel_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUX_SER_PARITY_EN
            parity_q   <= 1'b0;
            par_beat_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MUX_SER_PARITY_EN
            parity_q   <= parity_d;
            par_beat_q <= par_beat_d;
`endif
        end
    end

    // next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        sout_d   = sout_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_ld_c = 1'b0;
        cnt_en_c = 1'b0;
`ifdef MUX_SER_PARITY_EN
        parity_d   = parity_q;
        par_beat_d = par_beat_q;
`endif
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.load) begin
                    w_d      = bus.data_in;
                    cnt_ld_c = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
`ifdef MUX_SER_PARITY_EN
                    parity_d   = ^bus.data_in;
                    par_beat_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
`ifdef MUX_SER_PARITY_EN
                if (par_beat_q) begin
                    sout_d     = parity_q;
                    par_beat_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    sout_d = bus.f;
                    if (sel_tc) begin
                        cnt_ld_c   = 1'b1;
                        par_beat_d = 1'b1;
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end
`else
                sout_d = bus.f;
                if (sel_tc) begin
                    cnt_ld_c = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_en_c = 1'b1;
                end
`endif
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.w          = w_q;
    assign bus.s          = sel;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Bench for mux_serializer_ctrl: both scan orders side by side, each with its own mux model.
module tb_mux_serializer_ctrl;
    import mux_ser_pkg::*;

`ifdef MUX_SER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif
    localparam int LAST = NB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mux_serializer_ctrl_if if0 ();
    mux_serializer_ctrl_if if1 ();

    assign if0.load    = load;
    assign if0.data_in = data_in;
    assign if0.f       = if0.w[if0.s];
    assign if1.load    = load;
    assign if1.data_in = data_in;
    assign if1.f       = if1.w[if1.s];

    mux_serializer_ctrl #(.DIR(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mux_serializer_ctrl #(.DIR(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Expected {valid, sout, done, busy, s, w} in cycle c after acceptance of d (c >= 1).
    function automatic logic [23:0] model(input int c, input logic [15:0] d, input int dir);
        logic       v, b, dn, sb;
        logic [3:0] sv;
        int         k;
        b  = (c >= 1) && (c <= LAST);
        v  = (c >= 2) && (c <= LAST);
        dn = (c == LAST);
        k  = c - 2;
        sb = 1'b0;
        if (v) sb = (k < 16) ? ((dir != 0) ? d[15-k] : d[k]) : ^d;
        if (c >= 1 && c <= 16) sv = (dir != 0) ? 4'(16 - c) : 4'(c - 1);
        else                   sv = (dir != 0) ? 4'd15 : 4'd0;
        return {v, sb, dn, b, sv, d};
    endfunction

    function automatic logic [23:0] obs(input int dir);
        if (dir != 0)
            return {if1.sout_valid, if1.sout & if1.sout_valid, if1.done, if1.busy, if1.s, if1.w};
        return {if0.sout_valid, if0.sout & if0.sout_valid, if0.done, if0.busy, if0.s, if0.w};
    endfunction

    task automatic test_reset();
        logic [23:0] exp_v;
        rst = 1'b1; load = 1'b0; data_in = 16'h0;
        repeat (2) @(negedge clk);
        for (int dir = 0; dir < 2; dir++) begin
            exp_v = {4'b0000, (dir != 0) ? 4'd15 : 4'd0, 16'h0};
            n_checks++;
            if (obs(dir) !== exp_v) begin
                n_fail++;
                $display("FAIL reset dir=%0d got=%h want=%h", dir, obs(dir), exp_v);
            end
        end
        rst = 1'b0;
        data_in = 16'hBEEF;
        repeat (3) @(negedge clk);
        for (int dir = 0; dir < 2; dir++) begin
            exp_v = {4'b0000, (dir != 0) ? 4'd15 : 4'd0, 16'h0};
            n_checks++;
            if (obs(dir) !== exp_v) begin
                n_fail++;
                $display("FAIL idle_hold dir=%0d got=%h want=%h", dir, obs(dir), exp_v);
            end
        end
    endtask

    // Starts at a negedge in IDLE; returns the collected streams of both orders.
    task automatic test_transfer(input logic [15:0] d, output logic [16:0] st0, output logic [16:0] st1);
        int beats;
        st0 = '0; st1 = '0; beats = 0;
        data_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= LAST + 1; c++) begin
            for (int dir = 0; dir < 2; dir++) begin
                n_checks++;
                if (obs(dir) !== model(c, d, dir)) begin
                    n_fail++;
                    $display("FAIL transfer d=%h dir=%0d cycle=%0d got=%h want=%h", d, dir, c, obs(dir), model(c, d, dir));
                end
            end
            if (if0.sout_valid && c >= 2 && c - 2 < 17) begin
                st0[c-2] = if0.sout;
                beats++;
            end
            if (if1.sout_valid && c >= 2 && c - 2 < 17) st1[c-2] = if1.sout;
            data_in = 16'($urandom);
            @(negedge clk);
        end
        n_checks++;
        if (beats != NB) begin
            n_fail++;
            $display("FAIL valid_beats d=%h got=%0d want=%0d", d, beats, NB);
        end
    endtask

    task automatic test_vectors();
        logic [16:0] st0, st1;
        test_transfer(16'hA5C3, st0, st1);
        n_checks++;
        if (st0[15:0] !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL stream_a5c3_lsb got=%h want=%h", st0[15:0], 16'hA5C3);
        end
`ifdef MUX_SER_PARITY_EN
        n_checks++;
        if (st0[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_a5c3 got=%b want=0", st0[16]);
        end
`endif
        test_transfer(16'h8001, st0, st1);
        n_checks++;
        if (st1[15:0] !== 16'h8001) begin
            n_fail++;
            $display("FAIL stream_8001_msb got=%h want=%h", st1[15:0], 16'h8001);
        end
`ifdef MUX_SER_PARITY_EN
        test_transfer(16'h0001, st0, st1);
        n_checks++;
        if (st0[16] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_0001 got=%b want=1", st0[16]);
        end
`endif
    endtask

    task automatic test_ignore_load();
        logic [15:0] d1, d2;
        logic [16:0] st0, st1;
        d1 = 16'($urandom);
        d2 = ~d1;
        data_in = d1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= LAST; c++) begin
            for (int dir = 0; dir < 2; dir++) begin
                n_checks++;
                if (obs(dir) !== model(c, d1, dir)) begin
                    n_fail++;
                    $display("FAIL ignore_load dir=%0d cycle=%0d got=%h want=%h", dir, c, obs(dir), model(c, d1, dir));
                end
            end
            data_in = d2;
            load = (c == 5 || c == LAST);
            @(negedge clk);
        end
        load = 1'b0;
        // this cycle is IDLE; the next load must be accepted here
        test_transfer(d2, st0, st1);
    endtask

    task automatic test_back_to_back();
        int first2;
        first2 = 0;
        data_in = 16'hFFFF; load = 1'b1;
        @(negedge clk);
        data_in = 16'h0000;
        for (int c = 1; c <= 2 * (LAST + 1); c++) begin
            for (int dir = 0; dir < 2; dir++) begin
                logic [23:0] e;
                e = (c <= LAST + 1) ? model(c, 16'hFFFF, dir) : model(c - (LAST + 1), 16'h0000, dir);
                n_checks++;
                if (obs(dir) !== e) begin
                    n_fail++;
                    $display("FAIL back_to_back dir=%0d cycle=%0d got=%h want=%h", dir, c, obs(dir), e);
                end
            end
            if (c > LAST + 1 && first2 == 0 && if0.sout_valid) first2 = c;
            if (c == 2 * (LAST + 1)) load = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (first2 != LAST + 3) begin
            n_fail++;
            $display("FAIL b2b_first_bit got=%0d want=%0d", first2, LAST + 3);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic [16:0] st0, st1;
        logic [23:0] exp_v;
        d = 16'($urandom);
        data_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c < 9; c++) begin
            for (int dir = 0; dir < 2; dir++) begin
                n_checks++;
                if (obs(dir) !== model(c, d, dir)) begin
                    n_fail++;
                    $display("FAIL pre_abort dir=%0d cycle=%0d got=%h want=%h", dir, c, obs(dir), model(c, d, dir));
                end
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        for (int dir = 0; dir < 2; dir++) begin
            exp_v = {4'b0000, (dir != 0) ? 4'd15 : 4'd0, 16'h0};
            n_checks++;
            if (obs(dir) !== exp_v) begin
                n_fail++;
                $display("FAIL async_abort dir=%0d got=%h want=%h", dir, obs(dir), exp_v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_transfer(16'($urandom), st0, st1);
    endtask

    task automatic test_random();
        logic [16:0] st0, st1;
        for (int i = 0; i < 6; i++) begin
            int gap;
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                load = 1'b0;
                @(negedge clk);
                n_checks++;
                if (if0.busy !== 1'b0 || if1.sout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_gap busy=%b valid=%b want=0,0", if0.busy, if1.sout_valid);
                end
            end
            test_transfer(16'($urandom), st0, st1);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_serializer_ctrl.md
# mux_serializer_ctrl

Sequential front-end for the 16:1 select tree (`mux16to1`). It captures a 16-bit word on a load request and drives that word onto the mux data inputs. It then steps the 4-bit select through all 16 positions and registers the mux output `f` into a serial bitstream with a valid strobe. The block sits directly upstream of the mux, which feeds `f` back combinationally, and turns the combinational selector into a parallel-to-serial converter.

## Interface
- `DIR`, default 0: scan order; 0 = select counts 0→15 (LSB first), 1 = select counts 15→0 (MSB first).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  start request; sampled only in IDLE.
- `data_in`  in  16  word to serialize; captured when `load` is accepted.
- `w`  out  16  held word, wired to the mux `w` input.
- `s`  out  4  select, wired to the mux `s` input.
- `f`  in  1  mux output, a combinational function of `w` and `s`.
- `sout`  out  1  registered serial data bit.
- `sout_valid`  out  1  `sout` carries a valid bit this cycle.
- `busy`  out  1  high from the cycle after load acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse on the last valid bit.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Reset drives the FSM to IDLE.
- Reset state: `w`=0, `s`=(DIR ? 15 : 0), `sout`=0, `sout_valid`=0, `busy`=0, `done`=0.
- In IDLE with `load`=1: `w`←`data_in`, `s`←start value, go to SHIFT. In IDLE with `load`=0, hold.
- In SHIFT, each cycle:
  - `sout`←`f` and `sout_valid`←1.
  - `s` advances by +1 (DIR=0) or −1 (DIR=1).
  - When the terminal select (15, or 0 for DIR=1) is sampled, go to DONE and reload `s` to the start value.
- In DONE: `done`=1, `busy`=1, and `sout_valid` is high for the final bit. Go to IDLE next cycle.
- `load` during SHIFT or DONE is ignored, with no queuing. `data_in` changes after acceptance have no effect.
- `w` holds its value after completion until the next accepted load.
- Reset asserted mid-operation aborts the transfer immediately: no `done` pulse, and all outputs return to reset values asynchronously.
- `sout_valid` is high for exactly 16 consecutive cycles per transfer (17 with parity).

## Timing
- Cycle 0: `load` accepted. Cycles 1–16: SHIFT with `s`=0..15 (DIR=0).
- `sout` for select k appears one cycle after `s`=k: `sout_valid` is high in cycles 2–17.
- Cycle 17: DONE, with `done`=1 coinciding with the last `sout_valid`.
- `busy` is high in cycles 1–17. A new `load` is accepted no earlier than cycle 18.
- Load-to-first-bit latency is 2 cycles. Throughput is 1 bit/cycle, with 2 idle cycles between back-to-back words.

## Configuration
- `MUX_SER_PARITY_EN` defined:
  - Even parity of `data_in` is computed and registered at load.
  - After the 16th select is sampled, one extra SHIFT beat drives the parity bit on `sout`, ignoring `f`.
  - DONE moves to cycle 18, `sout_valid` spans 17 beats, and `busy` spans cycles 1–18.
- `MUX_SER_PARITY_EN` undefined: no parity logic or register; timing is exactly as above.

## Structure
- Package `mux_ser_pkg`:
  - constants `DATA_W`=16 and `SEL_W`=4;
  - state enum {IDLE, SHIFT, DONE};
  - start/terminal select helper constants for each DIR value.
- Sub-module `sel_counter`: 4-bit loadable up/down counter.
  - Inputs: `clk`, `rst`, `ld`, `en`, `up`.
  - Outputs: `cnt` and a terminal flag `tc`.
  - The top-level instantiates it for `s`.
- The mux itself is not instantiated inside this block; `w`, `s` and `f` connect at the parent.

## Test plan
- DIR=0, `load` with `data_in`=16'hA5C3 → `sout` over valid beats = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `done` in cycle 17.
- DIR=1, `data_in`=16'h8001 → first `sout`=1, then 14 zeros, last `sout`=1; `s` observed 15→0.
- `load` pulsed in cycles 5 and 17 with a different `data_in` → ignored; output stream and `w` unchanged; next load accepted at cycle 18.
- `rst` asserted in cycle 9 mid-transfer → `sout_valid`/`busy`/`w`/`s` immediately at reset values; no `done`; next `load` starts a clean transfer.
- With `MUX_SER_PARITY_EN`: `data_in`=16'hA5C3 → 17th bit = 0. With `data_in`=16'h0001 → 17th bit = 1; `done` in cycle 18.
- Back-to-back: `load` held high continuously with 16'hFFFF then 16'h0000 → two transfers, the second's first valid bit in cycle 20, with no overlap.
